// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES_DEF   = 2;
  localparam int DB_STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous inputs, with a synchronous
// active-low reset that loads a configurable level into every stage.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronizes a bouncing button level and only changes the registered `up`
// output after STABLE_CYCLES consecutive samples at the new level.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = DB_SYNC_STAGES_DEF,
  parameter int   STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic btn_raw,
  output logic up,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int              CNT_W       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam db_state_t       RESET_STATE = RESET_LEVEL ? ST_HIGH : ST_LOW;
  localparam bit              SKIP_WAIT   = (STABLE_CYCLES == 1);

  logic             btn_sync;
  db_state_t        state;
  db_state_t        state_d;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             up_d;
  logic             rise_d;
  logic             fall_d;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (btn_raw),
    .q       (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= RESET_STATE;
      stab_cnt   <= '0;
      up         <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      stab_cnt   <= cnt_d;
      up         <= up_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = stab_cnt;
    unique case (state)
      ST_LOW: begin
        if (btn_sync) begin
          state_d = SKIP_WAIT ? ST_HIGH : ST_WAIT_HIGH;
          cnt_d   = SKIP_WAIT ? '0 : CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!btn_sync) begin
          state_d = SKIP_WAIT ? ST_LOW : ST_WAIT_LOW;
          cnt_d   = SKIP_WAIT ? '0 : CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        if (!btn_sync) begin
          // Level fell back before qualifying: treat it as a glitch.
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (stab_cnt == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (stab_cnt != CNT_MAX) begin
          cnt_d = stab_cnt + CNT_ONE;
        end
      end
      ST_WAIT_LOW: begin
        if (btn_sync) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (stab_cnt == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (stab_cnt != CNT_MAX) begin
          cnt_d = stab_cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses are derived from the next level so they land on the same edge as `up`.
  always_comb begin
    up_d   = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
    rise_d = up_d & ~up;
    fall_d = ~up_d & up;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and randomized bench for button_debouncer (STABLE_CYCLES 4 and 1).
module tb_button_debouncer;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic btn_raw = 1'b1;
  logic up0, rise0, fall0;
  logic up1, rise1, fall1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  button_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) dut0 (
    .clk(clk), .n_reset(n_reset), .btn_raw(btn_raw),
    .up(up0), .rise_pulse(rise0), .fall_pulse(fall0)
  );

  button_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .n_reset(n_reset), .btn_raw(btn_raw),
    .up(up1), .rise_pulse(rise1), .fall_pulse(fall1)
  );

  // Reference model: a sample log of what the debouncer sees after the
  // synchronizer delay, and "flip when the last C samples since the previous
  // flip all disagree with the current level".
  localparam int LOG_N = 4096;
  int   k = 0;
  logic seen_log [0:LOG_N-1];
  logic sync_q [$];
  logic up_m [0:1];
  logic rise_m [0:1];
  logic fall_m [0:1];
  int   last_flip [0:1];
  int   cyc_m [0:1] = '{4, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_edge(input logic raw, input logic rst_n);
    logic seen;
    logic all_differ;
    k++;
    if (!rst_n) begin
      sync_q = {1'b1, 1'b1};
      for (int i = 0; i < 2; i++) begin
        up_m[i] = 1'b1; rise_m[i] = 1'b0; fall_m[i] = 1'b0; last_flip[i] = k;
      end
    end else begin
      seen = sync_q[0];
      void'(sync_q.pop_front());
      sync_q.push_back(raw);
      seen_log[k % LOG_N] = seen;
      for (int i = 0; i < 2; i++) begin
        rise_m[i] = 1'b0;
        fall_m[i] = 1'b0;
        if (k - last_flip[i] >= cyc_m[i]) begin
          all_differ = 1'b1;
          for (int j = 0; j < cyc_m[i]; j++)
            if (seen_log[(k - j) % LOG_N] == up_m[i]) all_differ = 1'b0;
          if (all_differ) begin
            up_m[i]      = ~up_m[i];
            rise_m[i]    = up_m[i];
            fall_m[i]    = ~up_m[i];
            last_flip[i] = k;
          end
        end
      end
    end
  endtask

  task automatic edge_step(input logic raw, input logic rst_n);
    @(negedge clk);
    btn_raw = raw;
    n_reset = rst_n;
    @(posedge clk);
    model_edge(raw, rst_n);
    #1;
    check("up_c4",   32'(up0),   32'(up_m[0]));
    check("rise_c4", 32'(rise0), 32'(rise_m[0]));
    check("fall_c4", 32'(fall0), 32'(fall_m[0]));
    check("up_c1",   32'(up1),   32'(up_m[1]));
    check("rise_c1", 32'(rise1), 32'(rise_m[1]));
    check("fall_c1", 32'(fall1), 32'(fall_m[1]));
  endtask

  // E0 is the first edge driven here; reports edges from E0 until each `up` moves.
  task automatic run_until_up(input logic lvl, input int want0, input int want1,
                              input int want_rise, input int want_fall, input string tag);
    int n, n1, r, f;
    n = 0; n1 = -1; r = 0; f = 0;
    edge_step(lvl, 1'b1);
    r += int'(rise0); f += int'(fall0);
    if (n1 < 0 && up1 === lvl) n1 = n;
    while (up0 !== lvl && n < 30) begin
      edge_step(lvl, 1'b1);
      n++;
      r += int'(rise0); f += int'(fall0);
      if (n1 < 0 && up1 === lvl) n1 = n;
    end
    check({tag, "_lat_c4"}, 32'(n),  32'(want0));
    check({tag, "_lat_c1"}, 32'(n1), 32'(want1));
    check({tag, "_rise_cnt"}, 32'(r), 32'(want_rise));
    check({tag, "_fall_cnt"}, 32'(f), 32'(want_fall));
    edge_step(lvl, 1'b1);
    edge_step(lvl, 1'b1);
  endtask

  initial begin
    int pulses;
    logic lvl;
    int len;

    // Reset with the button low: outputs held at the reset level.
    for (int i = 0; i < 3; i++) edge_step(1'b0, 1'b0);
    check("rst_state", 32'(dut0.state), 32'(ST_HIGH));
    check("rst_cnt",   32'(dut0.stab_cnt), 32'd0);

    // Clean press released straight out of reset.
    run_until_up(1'b0, 5, 2, 0, 1, "press");

    // Bounce then settle high.
    edge_step(1'b0, 1'b1); edge_step(1'b0, 1'b1);
    edge_step(1'b1, 1'b1); edge_step(1'b1, 1'b1);
    edge_step(1'b0, 1'b1); edge_step(1'b0, 1'b1);
    run_until_up(1'b1, 5, 2, 1, 0, "bounce");

    // Near-threshold glitch: three low samples must be absorbed.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b0, 1'b1);
      pulses += int'(rise0) + int'(fall0);
    end
    for (int i = 0; i < 8; i++) begin
      edge_step(1'b1, 1'b1);
      pulses += int'(rise0) + int'(fall0);
    end
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_up",     32'(up0), 32'd1);
    check("glitch_state",  32'(dut0.state), 32'(ST_HIGH));

    // Reset while two samples into a falling wait.
    for (int i = 0; i < 4; i++) edge_step(1'b0, 1'b1);
    check("midwait_state", 32'(dut0.state), 32'(ST_WAIT_LOW));
    check("midwait_cnt",   32'(dut0.stab_cnt), 32'd2);
    edge_step(1'b0, 1'b0);
    check("midrst_state", 32'(dut0.state), 32'(ST_HIGH));
    check("midrst_cnt",   32'(dut0.stab_cnt), 32'd0);
    run_until_up(1'b0, 5, 2, 0, 1, "midwait");

    // STABLE_CYCLES=1 toggling: one pulse per toggle.
    for (int t = 0; t < 4; t++) begin
      lvl = (t % 2 == 0) ? 1'b1 : 1'b0;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
        edge_step(lvl, 1'b1);
        pulses += int'(rise1) + int'(fall1);
      end
      check("c1_toggle_pulses", 32'(pulses), 32'd1);
    end

    // Randomized bursts with occasional reset.
    for (int seg = 0; seg < 70; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++)
        edge_step(lvl, ($urandom_range(0, 49) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, asynchronous push-button or switch level into a clean direction control for the up/down `counter`. The block synchronizes the input and rejects bounce shorter than a programmable number of cycles. It drives the counter's `up` input directly and provides single-cycle edge pulses for logging or display logic. One instance sits between each board input pin and the counter it steers.

## Interface
- `SYNC_STAGES`, 2: number of synchronizer flops on `btn_raw`; minimum 2.
- `STABLE_CYCLES`, 4: consecutive synchronized samples at a new level required before `up` changes; minimum 1.
- `RESET_LEVEL`, 1'b1: value of `up` and of all synchronizer flops while in reset.
- `clk` input 1: single clock; all state updates on its rising edge.
- `n_reset` input 1: reset, synchronous, active-low; sampled only on the `clk` rising edge.
- `btn_raw` input 1: asynchronous, bouncing button/switch level.
- `up` output 1: debounced level, registered; feeds the counter's `up`.
- `rise_pulse` output 1: high for exactly one cycle when `up` goes 0→1.
- `fall_pulse` output 1: high for exactly one cycle when `up` goes 1→0.

## Operation
- Synchronizer: a `SYNC_STAGES`-deep shift register on `btn_raw`. The last stage is `btn_sync`. No logic reads `btn_raw` or the intermediate stages.
- FSM states: `ST_LOW`, `ST_WAIT_HIGH`, `ST_HIGH`, `ST_WAIT_LOW`. The state determines `up`: 0 in `ST_LOW`/`ST_WAIT_HIGH`, 1 in `ST_HIGH`/`ST_WAIT_LOW`. `up` is a flop, not decoded.
- Stability counter `stab_cnt`, width `$clog2(STABLE_CYCLES+1)`, saturating, never wraps.
- Transitions out of the stable states (`ST_LOW`, `ST_HIGH`):
  - If `btn_sync` differs from `up`: enter `ST_WAIT_HIGH` (from `ST_LOW`) or `ST_WAIT_LOW` (from `ST_HIGH`) and load `stab_cnt`=1.
  - If `STABLE_CYCLES`==1: skip the wait state and flip `up` on that edge.
- Transitions out of the wait states:
  - If `btn_sync` returns to the current `up` level: go back to the stable state, `stab_cnt`=0, `up` unchanged. This is glitch rejection.
  - Otherwise increment `stab_cnt`. When the increment would reach `STABLE_CYCLES`: move to the opposite stable state, flip `up`, clear `stab_cnt`, and assert the matching pulse.
- Pulses are registered and asserted on the same edge that updates `up`. `rise_pulse` and `fall_pulse` are never high together.
- Reset, at any time including mid-wait:
  - All synchronizer flops = `RESET_LEVEL`.
  - State = `ST_HIGH` if `RESET_LEVEL` else `ST_LOW`.
  - `up` = `RESET_LEVEL`, `stab_cnt` = 0, both pulses = 0.
  - No pulse is generated on the reset edge or on the release edge.

## Timing
- Edge numbering: E0 is the edge that first captures a new `btn_raw` level into stage 1.
- `btn_sync` shows the new level after edge E0+`SYNC_STAGES`-1.
- `up` changes at edge E0+`SYNC_STAGES`+`STABLE_CYCLES`-1, provided the level held at every sample. Defaults: 5 edges after E0.
- Minimum pulse width that can propagate: `STABLE_CYCLES` synchronized samples. Anything shorter is fully absorbed and produces no pulse.
- Back-to-back toggles: after `up` flips, a reversal needs another full `STABLE_CYCLES` samples. There is no hold-off beyond that.
- `btn_raw` changing in the same cycle that `n_reset` is low: reset wins. The synchronizer reloads `RESET_LEVEL`.
- Outputs are glitch-free flops. They may drive the counter's `up` directly with no further registering.

## Structure
- Package `debounce_pkg` holds:
  - typedef enum `db_state_t` with the four states.
  - Default constants `DB_SYNC_STAGES_DEF`=2 and `DB_STABLE_CYCLES_DEF`=4.
- Sub-module `sync_ff`, a parameterized N-stage single-bit synchronizer with synchronous active-low reset and reset value parameter. It is reused for the team's other asynchronous inputs.
- The top module contains only `sync_ff`, the FSM, `stab_cnt`, and the output flops.

## Test plan
Defaults for all scenarios (except scenario 5): `SYNC_STAGES`=2, `STABLE_CYCLES`=4, `RESET_LEVEL`=1, 10 ns clock.
- Reset: hold `n_reset`=0 for 3 edges with `btn_raw`=0. Required: `up`=1 and both pulses 0 throughout reset and on the release edge.
- Clean press: after reset, drive `btn_raw`=0 and hold it. Required: `up` 1→0 exactly 5 edges after capture, `fall_pulse` high for 1 cycle, `rise_pulse` stays 0.
- Bounce rejection:
  - Stimulus: `btn_raw` toggles 0,1,0,1 with 2-cycle spacing, then settles at 1 while `up`=0.
  - Required: no change during the bounce. `up`=1 exactly 5 edges after the final stable capture. Exactly one `rise_pulse`.
- Near-threshold glitch: while `up`=1, drive `btn_raw`=0 for 3 cycles, then back to 1. Required: `up` stays 1, no pulses, FSM returns to `ST_HIGH`.
- `STABLE_CYCLES`=1 instance: toggle `btn_raw`. Required: `up` follows 2 edges after capture, and every toggle gives a single pulse.
- Reset mid-wait: assert `n_reset`=0 when `stab_cnt`=2 in `ST_WAIT_LOW`. Required: `up`=1, `stab_cnt`=0, no pulse. After release with `btn_raw` still 0, `up` falls a full 5 edges later.
